// File: rtl/rs_pkg.sv
// rs_pkg -- shared constants, types and GF(2^8) helpers for the RS(255,239)
// systematic encoder (top module reed_solomon_decoder).
//   N, K, NPAR : codeword length, message length, parity symbol count
//   PRIM_POLY  : field polynomial x^8+x^4+x^3+x^2+1
//   GEN        : generator coefficients g0..g15 of prod(x - alpha^i), i=0..15
//                (monic, so the x^16 term is implied)
//   sym_t      : one GF(2^8) symbol
package rs_pkg;

  localparam int N    = 255;
  localparam int K    = 239;
  localparam int NPAR = 16;
  localparam logic [8:0] PRIM_POLY = 9'h11D;

  typedef logic [7:0] sym_t;
  typedef logic [NPAR-1:0][7:0] gen_t;

  // Which half of the codeword the symbol counter is in.
  typedef enum logic {
    PH_MSG = 1'b0,
    PH_PAR = 1'b1
  } phase_t;

  // Shift-and-add multiply. When b is a constant, this reduces to a fixed XOR
  // network after constant propagation.
  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ PRIM_POLY[7:0]) : (x << 1);
    end
    return p;
  endfunction

  // Expands prod(x + alpha^i) one root at a time; evaluated at elaboration.
  function automatic gen_t calc_gen();
    logic [NPAR:0][7:0] g;
    sym_t root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int d = NPAR; d > 0; d--) g[d] = g[d-1] ^ gf_mul(g[d], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[NPAR-1:0];
  endfunction

  localparam gen_t GEN = calc_gen();

endpackage

// File: rtl/gf256_mul_const.sv
// gf256_mul_const -- combinational multiply of a symbol by a fixed GF(2^8)
// coefficient.
//   COEF : constant multiplier
//   a    : input symbol
//   y    : a * COEF in GF(2^8) (poly 0x11D)
module gf256_mul_const
  import rs_pkg::*;
#(
  parameter logic [7:0] COEF = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = gf_mul(a, COEF);

endmodule

// File: rtl/reed_solomon_decoder.sv
// reed_solomon_decoder -- free-running streaming systematic RS(255,239)
// encoder over GF(2^8), 16 parity symbols, one symbol per clock.
//   clk         : clock, rising edge
//   rst_n       : synchronous, active-HIGH reset (name kept from the codebase)
//   data_in     : message symbol, accepted while cnt is 0..K-1, ignored otherwise
//   encode_out  : registered codeword symbol, 1 clk latency; message symbols
//                 pass through, then parity is emitted highest degree first
//   frame_start : (only with RS_FRAME_START_EN defined) high in the clk where
//                 encode_out carries codeword symbol 0
// Data is streamed continuously: there is no valid/ready handshake, every clk
// carries exactly one symbol and the frame position is given by cnt alone.
module reed_solomon_decoder
  import rs_pkg::NPAR, rs_pkg::GEN, rs_pkg::sym_t, rs_pkg::phase_t,
         rs_pkg::PH_MSG, rs_pkg::PH_PAR;
#(
  parameter int N     = 255,
  parameter int K     = 239,
  parameter int SYM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SYM_W-1:0] data_in,
`ifdef RS_FRAME_START_EN
  output logic             frame_start,
`endif
  output logic [SYM_W-1:0] encode_out
);

  localparam int CW = $clog2(N);

  logic [CW-1:0]        cnt;
  logic [NPAR-1:0][7:0] par;
  logic [NPAR-1:0][7:0] par_eff;
  logic [NPAR-1:0][7:0] par_next;
  logic [NPAR-1:0][7:0] prod;
  sym_t                 din;
  sym_t                 fb;
  phase_t               phase;

  assign din = data_in;

  // Symbol counter is the only state; the phase is decoded from it.
  always_comb begin
    phase   = (cnt < CW'(K)) ? PH_MSG : PH_PAR;
    // At cnt 0 the remainder is forced to zero so no residue leaks between
    // frames, whatever par holds.
    par_eff = (cnt == '0) ? '0 : par;
    fb      = (phase == PH_MSG) ? (din ^ par_eff[NPAR-1]) : '0;
  end

  for (genvar gi = 0; gi < NPAR; gi++) begin : g_mul
    gf256_mul_const #(
      .COEF(GEN[gi])
    ) u_mul (
      .a(fb),
      .y(prod[gi])
    );
  end

  // Message phase: LFSR division by g(x). Parity phase: plain shift-out.
  always_comb begin
    par_next = '0;
    if (phase == PH_MSG) begin
      par_next[0] = prod[0];
      for (int i = 1; i < NPAR; i++) par_next[i] = par_eff[i-1] ^ prod[i];
    end else begin
      par_next[0] = '0;
      for (int i = 1; i < NPAR; i++) par_next[i] = par[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt        <= '0;
      par        <= '0;
      encode_out <= '0;
`ifdef RS_FRAME_START_EN
      frame_start <= 1'b0;
`endif
    end else begin
      cnt        <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
      par        <= par_next;
      encode_out <= (phase == PH_MSG) ? din : par[NPAR-1];
`ifdef RS_FRAME_START_EN
      frame_start <= (cnt == '0);
`endif
    end
  end

endmodule

// File: tb/tb_reed_solomon_decoder.sv
// tb_reed_solomon_decoder -- randomized scoreboard bench for the RS(255,239)
// encoder. A driver pushes the expected output of every clk into exp_q from a
// polynomial-division reference model; a monitor pops and compares, and also
// checks that every observed codeword has all 16 syndromes equal to zero.
// Honors RS_FRAME_START_EN when defined.
module tb_reed_solomon_decoder;

  localparam int N    = 255;
  localparam int K    = 239;
  localparam int NPAR = 16;

  // ---------------- clock / reset ----------------
  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] encode_out;
`ifdef RS_FRAME_START_EN
  logic       frame_start;
`endif

  always #5 clk = ~clk;

  reed_solomon_decoder #(
    .N(N), .K(K), .SYM_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
`ifdef RS_FRAME_START_EN
    .frame_start(frame_start),
`endif
    .encode_out(encode_out)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] sym;
    logic       fs;
    logic       in_rst;
    logic [7:0] idx;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] obs_par_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  logic [7:0] g_coef [0:NPAR];   // g_coef[d] = coefficient of x^d
  logic [7:0] m_buf  [0:N-1];
  logic [7:0] m_par  [0:NPAR-1]; // in transmit order
  int         m_pos = 0;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int x, p;
    x = int'(a);
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
    end
    return 8'(p);
  endfunction

  task automatic build_gen();
    logic [7:0] root;
    for (int d = 0; d <= NPAR; d++) g_coef[d] = 8'h00;
    g_coef[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int d = NPAR; d > 0; d--) g_coef[d] = g_coef[d-1] ^ gf_mul(g_coef[d], root);
      g_coef[0] = gf_mul(g_coef[0], root);
      root = gf_mul(root, 8'h02);
    end
  endtask

  // Remainder of m(x)*x^16 / g(x) by schoolbook long division; index 0 of the
  // work array is the highest-degree coefficient.
  task automatic compute_parity();
    logic [7:0] w [0:N-1];
    logic [7:0] c;
    for (int j = 0; j < N; j++) w[j] = (j < K) ? m_buf[j] : 8'h00;
    for (int j = 0; j < K; j++) begin
      c = w[j];
      w[j] = 8'h00;
      for (int d = 0; d < NPAR; d++) w[j+NPAR-d] = w[j+NPAR-d] ^ gf_mul(c, g_coef[d]);
    end
    for (int k = 0; k < NPAR; k++) m_par[k] = w[K+k];
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst_n   = rst;
    data_in = d;
    e = '0;
    if (rst) begin
      m_pos    = 0;
      e.in_rst = 1'b1;
    end else begin
      if (m_pos < K) begin
        m_buf[m_pos] = d;
        e.sym = d;
        if (m_pos == K - 1) compute_parity();
      end else begin
        e.sym = m_par[m_pos-K];
      end
      e.fs  = (m_pos == 0);
      e.idx = 8'(m_pos);
      m_pos = (m_pos == N - 1) ? 0 : m_pos + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] obs_cw [0:N-1];

  initial begin
    exp_t         e;
    logic [7:0]   s, a, s_or;
    logic [127:0] p;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (encode_out !== e.sym) begin
          n_err++;
          $display("FAIL encode_out idx=%0d rst=%0b: got %02h, required %02h",
                   e.idx, e.in_rst, encode_out, e.sym);
        end
`ifdef RS_FRAME_START_EN
        n_cmp++;
        if (frame_start !== e.fs) begin
          n_err++;
          $display("FAIL frame_start idx=%0d rst=%0b: got %0b, required %0b",
                   e.idx, e.in_rst, frame_start, e.fs);
        end
`endif
        if (!e.in_rst) begin
          obs_cw[e.idx] = encode_out;
          if (int'(e.idx) == N - 1) begin
            s_or = 8'h00;
            a    = 8'h01;
            for (int i = 0; i < NPAR; i++) begin
              s = 8'h00;
              for (int j = 0; j < N; j++) s = gf_mul(s, a) ^ obs_cw[j];
              s_or = s_or | s;
              a = gf_mul(a, 8'h02);
            end
            n_cmp++;
            if (s_or != 8'h00) begin
              n_err++;
              $display("FAIL syndrome: OR of syndromes %02h, required 00", s_or);
            end
            for (int k = 0; k < NPAR; k++) p[k*8 +: 8] = obs_cw[K+k];
            obs_par_q.push_back(p);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0]   msg_a [0:K-1];
  logic [7:0]   msg_b [0:K-1];
  logic [127:0] exp_p, pa, pb, pab;
  int           sz;

  initial begin
    build_gen();

    // Reset, then an all-zero frame: every symbol including parity is 0.
    repeat (3) drive(1'b1, 8'h00);
    repeat (N) drive(1'b0, 8'h00);

    // Incrementing ramp across a frame boundary (second frame starts at 0xFF).
    drive(1'b1, 8'h00);
    for (int i = 0; i < 290; i++) drive(1'b0, 8'(i));

    // Single 1 in the last message position: parity is g(x) itself.
    drive(1'b1, 8'h00);
    for (int i = 0; i < N; i++) drive(1'b0, (i == K - 1) ? 8'h01 : 8'h00);
    drain();
    for (int k = 0; k < NPAR; k++) exp_p[k*8 +: 8] = g_coef[NPAR-1-k];
    n_cmp++;
    if (obs_par_q.size() == 0 || obs_par_q[obs_par_q.size()-1] !== exp_p) begin
      n_err++;
      $display("FAIL impulse_parity: got %032h, required %032h",
               (obs_par_q.size() == 0) ? 128'h0 : obs_par_q[obs_par_q.size()-1], exp_p);
    end

    // Linearity: frames A, B, A^B back to back.
    for (int i = 0; i < K; i++) begin
      msg_a[i] = 8'($urandom_range(0, 255));
      msg_b[i] = 8'($urandom_range(0, 255));
    end
    drive(1'b1, 8'h00);
    for (int i = 0; i < N; i++) drive(1'b0, (i < K) ? msg_a[i] : 8'($urandom_range(0, 255)));
    for (int i = 0; i < N; i++) drive(1'b0, (i < K) ? msg_b[i] : 8'($urandom_range(0, 255)));
    for (int i = 0; i < N; i++) drive(1'b0, (i < K) ? (msg_a[i] ^ msg_b[i]) : 8'h00);
    drain();
    sz = obs_par_q.size();
    pa  = (sz >= 3) ? obs_par_q[sz-3] : 128'h0;
    pb  = (sz >= 3) ? obs_par_q[sz-2] : 128'h0;
    pab = (sz >= 3) ? obs_par_q[sz-1] : 128'h1;
    n_cmp++;
    if (pab !== (pa ^ pb)) begin
      n_err++;
      $display("FAIL linearity: got %032h, required %032h", pab, pa ^ pb);
    end

    // Reset asserted mid-frame at cnt 100 for 3 clks, then full random frames.
    drive(1'b1, 8'h00);
    for (int i = 0; i < 100; i++) drive(1'b0, 8'($urandom_range(0, 255)));
    repeat (3) drive(1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 3 * N; i++) drive(1'b0, 8'($urandom_range(0, 255)));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d outputs pending", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
